elm_mitch_div: RTL and testbench

- Pipelined approximate signed 16-bit divider using Mitchell logarithmic arithmetic. It is the inverse-direction companion of the ELM Mitchell multiplier: log(x) - log(y) followed by antilog, instead of log(x) + log(y).
- Sits in the approximate-arithmetic datapath behind a valid/ready stream interface.
- Three registered stages, full throughput, with backpressure.

---
 rtl/elm_mitch_div.sv | 222 ++++++++++++++++++++++
 tb/tb_elm_mitch_div.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elm_mitch_div.sv
// Three-stage pipelined approximate signed 16-bit divider (Mitchell log/antilog) with valid/ready flow control.
// Define ELM_MITCH_DIV_STATS_EN to add the op_count / div0_count statistics ports.
module elm_mitch_div #(
    parameter int FRAC_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        div0,
    output logic        sat
`ifdef ELM_MITCH_DIV_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  div0_count
`endif
);

    localparam int F  = FRAC_BITS;
    localparam int LW = F + 4;
    localparam int DW = F + 5;
    localparam int PW = F + 17;

    function automatic logic [15:0] mag16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    // log2 approximation: leading-one index as integer part, the next F bits as fraction.
    function automatic logic [LW-1:0] mitch_log(input logic [15:0] m);
        logic [3:0]    k;
        logic [15+F:0] sh;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) k = i[3:0];
        end
        sh = {m, {F{1'b0}}} >> k;
        return {k, sh[F-1:0]};
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [LW-1:0] s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d;
    logic          s1_sign_q, s1_sign_d, s1_zx_q, s1_zx_d, s1_zy_q, s1_zy_d, s1_xneg_q, s1_xneg_d;

    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_d_q, s2_d_d;
    logic          s2_sign_q, s2_sign_d, s2_zx_q, s2_zx_d, s2_zy_q, s2_zy_d, s2_xneg_q, s2_xneg_d;

    logic          out_valid_q, out_valid_d;
    logic [15:0]   q_q, q_d;
    logic          div0_q, div0_d, sat_q, sat_d;

    logic          s1_ready, s2_ready, s3_ready;
    logic [3:0]    e;
    logic [F-1:0]  mf;
    logic [PW-1:0] prod, qmag, limit;
    logic [15:0]   q_n;
    logic          sat_n, div0_n;

    // A stage may load when it is empty or its content moves on this cycle.
    assign s3_ready = ~out_valid_q | out_ready;
    assign s2_ready = ~s2_valid_q | s3_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_lx_d    = s1_lx_q;
        s1_ly_d    = s1_ly_q;
        s1_sign_d  = s1_sign_q;
        s1_zx_d    = s1_zx_q;
        s1_zy_d    = s1_zy_q;
        s1_xneg_d  = s1_xneg_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lx_d   = mitch_log(mag16(x));
                s1_ly_d   = mitch_log(mag16(y));
                s1_sign_d = x[15] ^ y[15];
                s1_zx_d   = (x == 16'd0);
                s1_zy_d   = (y == 16'd0);
                s1_xneg_d = x[15];
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d_d     = s2_d_q;
        s2_sign_d  = s2_sign_q;
        s2_zx_d    = s2_zx_q;
        s2_zy_d    = s2_zy_q;
        s2_xneg_d  = s2_xneg_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d_d    = {1'b0, s1_lx_q} - {1'b0, s1_ly_q};
                s2_sign_d = s1_sign_q;
                s2_zx_d   = s1_zx_q;
                s2_zy_d   = s1_zy_q;
                s2_xneg_d = s1_xneg_q;
            end
        end
    end

    // Antilog: (1.mf) * 2^e, then drop the F fraction bits (truncation toward zero).
    always_comb begin
        e     = s2_d_q[F+3:F];
        mf    = s2_d_q[F-1:0];
        prod  = {16'd0, 1'b1, mf} << e;
        qmag  = s2_d_q[DW-1] ? '0 : (prod >> F);
        limit = s2_sign_q ? PW'(32768) : PW'(32767);
        sat_n = 1'b0;
        if (qmag > limit) begin
            qmag  = limit;
            sat_n = 1'b1;
        end
        q_n    = s2_sign_q ? (~qmag[15:0] + 16'd1) : qmag[15:0];
        div0_n = 1'b0;
        if (s2_zy_q) begin
            div0_n = 1'b1;
            sat_n  = 1'b0;
            q_n    = s2_xneg_q ? 16'h8000 : 16'h7FFF;
        end else if (s2_zx_q) begin
            q_n   = 16'd0;
            sat_n = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        q_d         = q_q;
        div0_d      = div0_q;
        sat_d       = sat_q;
        if (s3_ready) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                q_d    = q_n;
                div0_d = div0_n;
                sat_d  = sat_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lx_q     <= '0;
            s1_ly_q     <= '0;
            s1_sign_q   <= 1'b0;
            s1_zx_q     <= 1'b0;
            s1_zy_q     <= 1'b0;
            s1_xneg_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_d_q      <= '0;
            s2_sign_q   <= 1'b0;
            s2_zx_q     <= 1'b0;
            s2_zy_q     <= 1'b0;
            s2_xneg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            div0_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lx_q     <= s1_lx_d;
            s1_ly_q     <= s1_ly_d;
            s1_sign_q   <= s1_sign_d;
            s1_zx_q     <= s1_zx_d;
            s1_zy_q     <= s1_zy_d;
            s1_xneg_q   <= s1_xneg_d;
            s2_valid_q  <= s2_valid_d;
            s2_d_q      <= s2_d_d;
            s2_sign_q   <= s2_sign_d;
            s2_zx_q     <= s2_zx_d;
            s2_zy_q     <= s2_zy_d;
            s2_xneg_q   <= s2_xneg_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            div0_q      <= div0_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign div0      = div0_q;
    assign sat       = sat_q;

`ifdef ELM_MITCH_DIV_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [7:0]  div0_count_q, div0_count_d;

    always_comb begin
        op_count_d   = op_count_q;
        div0_count_d = div0_count_q;
        if (out_valid_q && out_ready) begin
            op_count_d = op_count_q + 16'd1;
            if (div0_q && (div0_count_q != 8'hFF)) div0_count_d = div0_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q   <= '0;
            div0_count_q <= '0;
        end else begin
            op_count_q   <= op_count_d;
            div0_count_q <= div0_count_d;
        end
    end

    assign op_count   = op_count_q;
    assign div0_count = div0_count_q;
`endif

endmodule

// File: tb/tb_elm_mitch_div.sv
// Scoreboard bench for elm_mitch_div: accepted operands push an arithmetic-model result,
// a negedge monitor compares every presented output against the queue head.
module tb_elm_mitch_div;

    localparam int F = 4;

    typedef struct {
        logic [15:0] q;
        logic        div0;
        logic        sat;
    } exp_t;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, div0, sat;
    logic [15:0] x, y, q;
`ifdef ELM_MITCH_DIV_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  div0_count;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0, n_out = 0, n_div0 = 0;
    bit   rand_en = 0;

    elm_mitch_div #(.FRAC_BITS(F)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .div0(div0), .sat(sat)
`ifdef ELM_MITCH_DIV_STATS_EN
        , .op_count(op_count), .div0_count(div0_count)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mlog(input int m);
        int k = 0;
        if (m == 0) return 0;
        for (int i = 0; i < 16; i++) if (m >= (1 << i)) k = i;
        return k * (1 << F) + ((m - (1 << k)) * (1 << F)) / (1 << k);
    endfunction

    function automatic exp_t ref_div(input logic [15:0] xa, input logic [15:0] ya);
        exp_t   r;
        int     xi, yi, d, e, mf;
        bit     neg;
        longint qmag, lim;
        xi = int'($signed(xa));
        yi = int'($signed(ya));
        r.div0 = 0;
        r.sat  = 0;
        r.q    = 16'd0;
        if (yi == 0) begin
            r.div0 = 1;
            r.q    = (xi < 0) ? 16'h8000 : 16'h7FFF;
            return r;
        end
        if (xi == 0) return r;
        neg = (xi < 0) != (yi < 0);
        d = mlog(xi < 0 ? -xi : xi) - mlog(yi < 0 ? -yi : yi);
        if (d < 0) qmag = 0;
        else begin
            e    = d / (1 << F);
            mf   = d % (1 << F);
            qmag = (longint'((1 << F) + mf) << e) / (1 << F);
        end
        lim = neg ? 32768 : 32767;
        if (qmag > lim) begin
            qmag  = lim;
            r.sat = 1;
        end
        r.q = 16'(neg ? -qmag : qmag);
        return r;
    endfunction

    // Monitor: compare the presented output against the queue head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got q=%0d with no result pending (t=%0t)", q, $time);
            end else begin
                mon_e = sb[0];
                check("q", 32'(q), 32'(mon_e.q));
                check("div0", 32'(div0), 32'(mon_e.div0));
                check("sat", 32'(sat), 32'(mon_e.sat));
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                    if (mon_e.div0) n_div0++;
                end
            end
        end
        if (rst_n && in_valid && in_ready) sb.push_back(ref_div(x, y));
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        in_valid = 1;
        x = a;
        y = b;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 1000);
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corners[6] = '{16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h000A};
        if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 255));
        return 16'($urandom);
    endfunction

    logic [15:0] dir_x[9] = '{16'd100, -16'sd1000, 16'd5, 16'd32767, 16'h8000, -16'sd5, 16'd0, 16'h8000, 16'd1};
    logic [15:0] dir_y[9] = '{16'd10, 16'd7, 16'd20, 16'd1, 16'hFFFF, 16'd0, 16'd0, 16'd1, 16'h8000};

    initial begin
        int lat;
        rst_n = 1; in_valid = 0; x = 0; y = 0; out_ready = 1;
        #1 rst_n = 0;
        #10;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_q", 32'(q), 0);
        check("rst_div0", 32'(div0), 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Latency of a single operation with out_ready held high.
        in_valid = 1; x = 16'd100; y = 16'd10;
        @(negedge clk);
        check("accept_first", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("latency", 32'(lat), 3);
        drain();

        for (int i = 0; i < 9; i++) send(dir_x[i], dir_y[i]);
        drain();

        // Back-to-back stream with a mid-stream stall; the monitor checks hold stability.
        fork
            for (int i = 0; i < 8; i++) send(pick(), pick());
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                @(negedge clk);
                check("in_ready_full", 32'(in_ready), 0);
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();

        // Reset with results in flight: they must vanish.
        out_ready = 0;
        send(16'd300, 16'd3);
        send(-16'sd77, 16'd5);
        @(posedge clk);
        #1;
        rst_n = 0;
        sb.delete();
        n_out = 0;
        n_div0 = 0;
        #1;
        check("rst_flush_out_valid", 32'(out_valid), 0);
        check("rst_flush_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        send(16'd1234, -16'sd9);
        send(16'd50, 16'd0);
        drain();

        rand_en = 1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rand_en = 0;
        out_ready = 1;
        drain();

`ifdef ELM_MITCH_DIV_STATS_EN
        check("op_count", 32'(op_count), 32'(n_out % 65536));
        check("div0_count", 32'(div0_count), 32'(n_div0 > 255 ? 255 : n_div0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
